// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: CPU/DBG arbiter for the single-ported data memory (optional perf counters under DMEM_ARB_PERF_EN)
module dmem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 15
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       cpu_stall_cnt
`endif
);
  localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  typedef enum logic {ARB, LOCKED} state_t;
  state_t            state_q, state_d;
  logic              last_dbg_q, last_dbg_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              idle_q, idle_d;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_hold_q, dbg_hold_q;
  logic              arb_cpu, force_cpu, lock_exit, cnt_open;
  // Grants: round-robin in ARB, DBG priority in LOCKED except for the forced CPU slot
  always_comb begin
    arb_cpu   = cpu_req & (~dbg_req | last_dbg_q);
    force_cpu = (LOCK_MAX != 0) && (state_q == LOCKED) && (lock_cnt_q == CNT_W'(LOCK_MAX)) && cpu_req;
    cpu_gnt   = ~reset & ((state_q == ARB) ? arb_cpu : force_cpu);
    dbg_gnt   = ~reset & dbg_req & ((state_q == ARB) ? ~arb_cpu : ~force_cpu);
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_we    = cpu_gnt ? cpu_we : (dbg_gnt & dbg_we);
    mem_addr  = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
  end
  // Lock FSM next state, last-winner pointer, lock counter and DBG idle tracking
  always_comb begin
    lock_exit  = (state_q == LOCKED) && (~dbg_lock || (~dbg_req && idle_q));
    cnt_open   = (LOCK_MAX != 0) && (lock_cnt_q != CNT_W'(LOCK_MAX));
    last_dbg_d = cpu_gnt ? 1'b0 : dbg_gnt ? 1'b1 : last_dbg_q;
    state_d    = (state_q == ARB) ? ((dbg_gnt & dbg_lock) ? LOCKED : ARB) : (lock_exit ? ARB : LOCKED);
    lock_cnt_d = (state_q == ARB) ? ((dbg_gnt && dbg_lock && (LOCK_MAX != 0)) ? CNT_W'(1) : '0)
               : (lock_exit || force_cpu) ? '0
               : (dbg_gnt && cnt_open) ? lock_cnt_q + CNT_W'(1) : lock_cnt_q;
    idle_d     = (state_q == LOCKED) && ~lock_exit && ~dbg_req;
  end
  // Arbiter state plus registered read-valid and read-data hold
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ARB;
      last_dbg_q   <= 1'b1;
      lock_cnt_q   <= '0;
      idle_q       <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_hold_q   <= '0;
      dbg_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      lock_cnt_q   <= lock_cnt_d;
      idle_q       <= idle_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (cpu_rvalid_q) cpu_hold_q <= mem_rdata;
      if (dbg_rvalid_q) dbg_hold_q <= mem_rdata;
    end
  end
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
  assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_hold_q;
`ifdef DMEM_ARB_PERF_EN
  // Saturating counters of contended cycles and CPU stall cycles
  always_ff @(posedge CLK) begin
    if (reset) begin
      conflict_cnt  <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      if (cpu_req & dbg_req & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 16'd1;
      if (cpu_stall & ~&cpu_stall_cnt) cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a rule-level arbitration model and memory model
module tb_dmem_port_arbiter;
  localparam int LM = 15;
  logic CLK = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic dbg_req = 0, dbg_lock = 0, dbg_we = 0, dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_addr = 0, dbg_wdata = 0, dbg_rdata;
  logic mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_cnt, cpu_stall_cnt;
  int m_conf = 0, m_stall = 0;
`endif
  always #5 CLK = ~CLK;
  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LM)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );
  logic [7:0] mem [256];
  logic [7:0] refmem [256];
  always @(posedge CLK) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct {logic [7:0] d; int due;} exp_t;
  exp_t cq[$], dq[$];
  int n_checks = 0, n_fail = 0;
  bit m_locked = 0, m_last_dbg = 1;
  int m_lgr = 0, m_idle = 0;
  bit sc, sd;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic creq(input bit we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic dreq(input bit we, input logic [7:0] a, input logic [7:0] d);
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask
  task automatic step();
    bit ec, ed, forced;
    @(negedge CLK);
    ec = 0; ed = 0;
    if (!reset) begin
      if (!m_locked) begin
        if (cpu_req && dbg_req) begin ec = m_last_dbg; ed = !m_last_dbg; end
        else begin ec = cpu_req; ed = dbg_req; end
      end else begin
        forced = (LM != 0) && (m_lgr >= LM) && cpu_req;
        ec = forced; ed = dbg_req && !forced;
      end
    end
    sc = cpu_gnt; sd = dbg_gnt;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(ed));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec));
    chk("mem_we", 32'(mem_we), 32'(ec ? cpu_we : ed ? dbg_we : 1'b0));
    chk("mem_addr", 32'(mem_addr), 32'(ec ? cpu_addr : ed ? dbg_addr : 8'h0));
    chk("mem_wdata", 32'(mem_wdata), 32'(ec ? cpu_wdata : ed ? dbg_wdata : 8'h0));
`ifdef DMEM_ARB_PERF_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
    chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(m_stall));
    if (reset) begin m_conf = 0; m_stall = 0; end
    else begin
      if (cpu_req && dbg_req && m_conf < 65535) m_conf++;
      if (cpu_req && !ec && m_stall < 65535) m_stall++;
    end
`endif
    if (ec) begin
      if (cpu_we) refmem[cpu_addr] = cpu_wdata;
      else cq.push_back('{refmem[cpu_addr], cyc + 1});
    end
    if (ed) begin
      if (dbg_we) refmem[dbg_addr] = dbg_wdata;
      else dq.push_back('{refmem[dbg_addr], cyc + 1});
    end
    if (reset) begin
      m_locked = 0; m_last_dbg = 1; m_lgr = 0; m_idle = 0;
      cq.delete(); dq.delete();
    end else begin
      if (ec) m_last_dbg = 0;
      if (ed) m_last_dbg = 1;
      if (!m_locked) begin
        if (ed && dbg_lock) begin m_locked = 1; m_lgr = 1; m_idle = 0; end
      end else begin
        if (ec) m_lgr = 0;
        if (ed) m_lgr++;
        if (!dbg_lock || (!dbg_req && m_idle >= 1)) begin m_locked = 0; m_lgr = 0; m_idle = 0; end
        else m_idle = dbg_req ? 0 : m_idle + 1;
      end
    end
    @(posedge CLK); #1;
    if (sc) cpu_req = 0;
    if (sd) dbg_req = 0;
  endtask
  task automatic mon();
    bit ev;
    if (reset) begin
      while (cq.size() > 0 && cq[0].due <= cyc) void'(cq.pop_front());
      while (dq.size() > 0 && dq[0].due <= cyc) void'(dq.pop_front());
    end else begin
      ev = cq.size() > 0 && cq[0].due == cyc;
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev));
      if (ev) begin chk("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].d)); void'(cq.pop_front()); end
      ev = dq.size() > 0 && dq[0].due == cyc;
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev));
      if (ev) begin chk("dbg_rdata", 32'(dbg_rdata), 32'(dq[0].d)); void'(dq.pop_front()); end
    end
  endtask
  initial forever begin
    @(posedge CLK); #2;
    mon();
  end
  initial begin
    int dn, cn, dbefore;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'(i + 1); refmem[i] = 8'(i + 1); end
    step();
    creq(0, 8'h10, 0); dreq(0, 8'h20, 0);
    step();
    reset = 0;
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst dbg_rvalid", 32'(dbg_rvalid), 0);
    chk("rst cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst dbg_rdata", 32'(dbg_rdata), 0);
    step();
    chk("t1 c0 cpu_gnt", 32'(sc), 1);
    chk("t1 c1 cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t1 c1 cpu_rdata", 32'(cpu_rdata), 32'h11);
    step();
    chk("t1 c1 dbg_gnt", 32'(sd), 1);
    chk("t1 c2 dbg_rvalid", 32'(dbg_rvalid), 1);
    chk("t1 c2 dbg_rdata", 32'(dbg_rdata), 32'h21);
    chk("t1 c2 cpu_rdata hold", 32'(cpu_rdata), 32'h11);
    creq(1, 8'h04, 8'h05);
    step();
    chk("t2 cpu_gnt", 32'(sc), 1);
    chk("t2 no rvalid", 32'(cpu_rvalid), 0);
    step();
    dbg_lock = 1; dreq(1, 8'h40, 8'h00);
    dn = 0; cn = 0; dbefore = -1;
    for (int t = 0; t < 100 && dn < 20; t++) begin
      step();
      if (sd) dn++;
      if (sc) begin cn++; if (dbefore < 0) dbefore = dn; end
      if (!cpu_req) creq(0, 8'($urandom_range(0, 255)), 0);
      if (!dbg_req && dn < 20) dreq(1, 8'(8'h40 + dn), 8'(dn));
    end
    chk("t3 dbg grants", 32'(dn), 20);
    chk("t3 dbg before cpu", 32'(dbefore), 15);
    chk("t3 cpu grants", 32'(cn), 1);
    dbg_lock = 0;
    step();
    chk("t3 exit cycle cpu_gnt", 32'(sc), 0);
    step();
    chk("t3 cpu after exit", 32'(sc), 1);
    dbg_lock = 1; dreq(0, 8'h33, 0);
    step();
    chk("t4 lock grant", 32'(sd), 1);
    step(); step();
    creq(0, 8'h44, 0);
    step();
    chk("t4 cpu after idle exit", 32'(sc), 1);
    dbg_lock = 0; creq(0, 8'h50, 0);
    step();
    chk("t5 cpu read gnt", 32'(sc), 1);
    reset = 1; creq(0, 8'h60, 0); dreq(0, 8'h61, 0);
    step();
    reset = 0;
    chk("t5 cpu_rvalid dropped", 32'(cpu_rvalid), 0);
    chk("t5 cpu_rdata cleared", 32'(cpu_rdata), 0);
    chk("t5 dbg_rdata cleared", 32'(dbg_rdata), 0);
    step();
    chk("t5 tie cpu wins", 32'(sc), 1);
    chk("t5 tie dbg loses", 32'(sd), 0);
    step();
`ifdef DMEM_ARB_PERF_EN
    reset = 1; cpu_req = 0; dbg_req = 0;
    step();
    reset = 0;
    for (int t = 0; t < 10; t++) begin
      if (!cpu_req) creq(0, 8'(t), 0);
      if (!dbg_req) dreq(0, 8'(t + 100), 0);
      step();
    end
    chk("t6 conflict_cnt", 32'(conflict_cnt), 10);
    chk("t6 cpu_stall_cnt", 32'(cpu_stall_cnt), 5);
    cpu_req = 0; dbg_req = 0;
    step();
`endif
    for (int t = 0; t < 800; t++) begin
      step();
      if (!cpu_req && $urandom_range(0, 99) < 60) creq(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      else if (cpu_req && $urandom_range(0, 99) < 3) cpu_req = 0;
      if (!dbg_req && $urandom_range(0, 99) < 70) dreq(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      else if (dbg_req && $urandom_range(0, 99) < 3) dbg_req = 0;
      if ($urandom_range(0, 99) < 3) dbg_lock = ~dbg_lock;
    end
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    step(); step(); step();
    chk("cpu queue drained", 32'(cq.size()), 0);
    chk("dbg queue drained", 32'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
